// File: rtl/random_word_arbiter_pkg.sv
// Shared arbiter types: word-builder state enum and a round-robin pick helper
// reused by every arbiter that hands out words from a common source.
package random_word_arbiter_pkg;

   localparam int MaxClients = 32;
   localparam int IdxW = 5;

   typedef enum logic {
      FILL  = 1'b0,
      READY = 1'b1
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [IdxW-1:0] index;
   } pick_t;

   // First set request at or above ptr, wrapping modulo clients; ptr < clients.
   function automatic pick_t rr_pick(input logic [MaxClients-1:0] req,
                                     input int unsigned ptr,
                                     input int unsigned clients);
      pick_t       pick;
      int unsigned idx;
      pick.valid = 1'b0;
      pick.index = '0;
      for (int unsigned i = 0; i < MaxClients; i++) begin
         idx = ptr + i;
         if (idx >= clients) idx = idx - clients;
         if (i < clients && !pick.valid && req[idx[IdxW-1:0]]) begin
            pick.valid = 1'b1;
            pick.index = idx[IdxW-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/random_word_arbiter_lfsr.sv
// Fibonacci LFSR with output enable and no reset; its sequence runs on from
// the power-up seed across any reset of the surrounding logic.
module Lfsr #(
   parameter int                Length = 48,
   parameter logic [Length-1:0] Taps   = 48'h8000_0000_005C,
   parameter logic [Length-1:0] Seed   = 48'hA1EA_1AC7_AE57
) (
   input  logic CLK,
   input  logic OE,
   output logic OUT
);

   logic [Length-1:0] state = Seed;

   always_ff @(posedge CLK) begin
      if (OE) state <= {state[Length-2:0], ^(state & Taps)};
   end

   assign OUT = state[Length-1];

endmodule

// File: rtl/random_word_arbiter.sv
// Builds Width-bit words from a shared LFSR and hands each one to exactly one
// requester, chosen round-robin, with a one-cycle ACK and a held DATA word.
module random_word_arbiter
   import random_word_arbiter_pkg::*;
#(
   parameter int                Clients = 4,
   parameter int                Width   = 16,
   parameter int                Length  = 48,
   parameter logic [Length-1:0] Taps    = 48'h8000_0000_005C,
   parameter logic [Length-1:0] Seed    = 48'hA1EA_1AC7_AE57
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [Clients-1:0] REQ,
   output logic [Clients-1:0] ACK,
   output logic [Width-1:0]   DATA
);

   localparam int CountW = (Width > 1) ? $clog2(Width) : 1;
   localparam int PtrW   = (Clients > 1) ? $clog2(Clients) : 1;

   state_t                state;
   state_t                state_next;
   logic [CountW-1:0]     count;
   logic [Width-1:0]      word;
   logic [Width:0]        word_shift;
   logic [PtrW-1:0]       ptr;
   logic [PtrW-1:0]       ptr_next;
   logic [Clients-1:0]    ack_next;
   logic [MaxClients-1:0] req_wide;
   logic                  oe;
   logic                  lfsr_out;
   pick_t                 pick;

   Lfsr #(
      .Length(Length),
      .Taps  (Taps),
      .Seed  (Seed)
   ) u_lfsr (
      .CLK(CLK),
      .OE (oe),
      .OUT(lfsr_out)
   );

   // The LFSR only advances while a word is being filled and never during reset.
   always_comb begin
      req_wide = '0;
      req_wide[Clients-1:0] = REQ;
      oe         = RST_N && (state == FILL);
      word_shift = {word, lfsr_out};
      pick       = rr_pick(req_wide, 32'(ptr), 32'(Clients));
      ack_next   = '0;
      for (int i = 0; i < Clients; i++) ack_next[i] = (pick.index == 5'(i));
      ptr_next = '0;
      if (int'(pick.index) + 1 < Clients) ptr_next = PtrW'(pick.index + 5'd1);
      state_next = state;
      case (state)
         FILL:    if (count == CountW'(Width - 1)) state_next = READY;
         READY:   if (pick.valid) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= FILL;
         count <= '0;
         word  <= '0;
         ptr   <= '0;
         ACK   <= '0;
         DATA  <= '0;
      end else begin
         state <= state_next;
         ACK   <= '0;
         if (state == FILL) begin
            word <= word_shift[Width-1:0];
            if (count == CountW'(Width - 1)) count <= '0;
            else                             count <= count + 1'b1;
         end else if (pick.valid) begin
            ACK  <= ack_next;
            DATA <= word;
            ptr  <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_random_word_arbiter.sv
// Directed bench: three arbiter instances exercised one after another on a shared clock.
module tb_random_word_arbiter;

   localparam logic [47:0] TAPS = 48'h8000_0000_005C;
   localparam logic [47:0] SEED = 48'hA1EA_1AC7_AE57;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, rst_c;
   logic [3:0]  req_a, req_b, ack_a, ack_b;
   logic [15:0] data_a, data_b;
   logic [0:0]  req_c, ack_c, data_c;

   int          checks = 0;
   int          failures = 0;
   logic [47:0] model_state;
   logic [15:0] w3, w4, w5, w6, dummy;
   logic [7:0]  c_bits;

   always #5 clk = ~clk;

   random_word_arbiter dut_a (.CLK(clk), .RST_N(rst_a), .REQ(req_a), .ACK(ack_a), .DATA(data_a));
   random_word_arbiter dut_b (.CLK(clk), .RST_N(rst_b), .REQ(req_b), .ACK(ack_b), .DATA(data_b));
   random_word_arbiter #(.Clients(1), .Width(1)) dut_c (
      .CLK(clk), .RST_N(rst_c), .REQ(req_c), .ACK(ack_c), .DATA(data_c));

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference stream: MSB of the register is the output bit, feedback enters at the LSB.
   task automatic model_word(output logic [15:0] w);
      w = '0;
      for (int i = 0; i < 16; i++) begin
         w = {w[14:0], model_state[47]};
         model_state = {model_state[46:0], ^(model_state & TAPS)};
      end
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      req_a = '0; req_b = '0; req_c = '0;
      step(3);
      check_output("a_reset_ack", 32'(ack_a), 32'h0);
      check_output("a_reset_data", 32'(data_a), 32'h0);

      model_state = SEED;
      model_word(dummy); model_word(dummy); model_word(dummy);
      model_word(w3); model_word(w4); model_word(w5); model_word(w6);

      // Single client holding its request
      rst_a = 1'b1; req_a = 4'b0001;
      step(16); check_output("a_ack_before_first", 32'(ack_a), 32'h0);
      step(1);  check_output("a_ack_e17", 32'(ack_a), 32'h1);
      check_output("a_data_e17", 32'(data_a), 32'hA1EA);
      step(1);  check_output("a_ack_pulse_end", 32'(ack_a), 32'h0);
      check_output("a_data_hold_e18", 32'(data_a), 32'hA1EA);
      step(15); check_output("a_ack_e33", 32'(ack_a), 32'h0);
      step(1);  check_output("a_ack_e34", 32'(ack_a), 32'h1);
      check_output("a_data_e34", 32'(data_a), 32'h1AC7);
      step(17); check_output("a_ack_e51", 32'(ack_a), 32'h1);
      check_output("a_data_e51", 32'(data_a), 32'hAE57);
      req_a = 4'b0000;

      // Request raised mid-FILL waits for READY
      step(4);  req_a = 4'b0100;
      step(12); check_output("a_ack_ready_entry", 32'(ack_a), 32'h0);
      step(1);  check_output("a_ack2", 32'(ack_a), 32'h4);
      check_output("a_data_w3", 32'(data_a), 32'(w3));
      req_a = 4'b0000;

      // Idle in READY: word held, DATA stable
      step(30); check_output("a_idle_ack", 32'(ack_a), 32'h0);
      check_output("a_idle_data", 32'(data_a), 32'(w3));
      req_a = 4'b0010;
      step(1);  check_output("a_ack1_latency", 32'(ack_a), 32'h2);
      check_output("a_data_w4_after_idle", 32'(data_a), 32'(w4));
      req_a = 4'b1010;

      // ptr is 2: client 3 then client 1
      step(17); check_output("a_rr_first", 32'(ack_a), 32'h8);
      check_output("a_data_w5", 32'(data_a), 32'(w5));
      step(17); check_output("a_rr_second", 32'(ack_a), 32'h2);
      check_output("a_data_w6", 32'(data_a), 32'(w6));
      req_a = 4'b0000;

      // Reset after 8 FILL edges: those 8 bits are lost, LFSR frozen during reset
      rst_b = 1'b1;
      step(8);
      rst_b = 1'b0;
      step(2);
      check_output("b_reset_ack", 32'(ack_b), 32'h0);
      check_output("b_reset_data", 32'(data_b), 32'h0);
      rst_b = 1'b1; req_b = 4'b1111;
      step(16); check_output("b_ack_gap0", 32'(ack_b), 32'h0);
      step(1);  check_output("b_grant0", 32'(ack_b), 32'h1);
      check_output("b_data_after_reset", 32'(data_b), 32'hEA1A);
      step(16); check_output("b_ack_gap1", 32'(ack_b), 32'h0);
      step(1);  check_output("b_grant1", 32'(ack_b), 32'h2);
      check_output("b_data2", 32'(data_b), 32'hC7AE);
      step(16); check_output("b_ack_gap2", 32'(ack_b), 32'h0);
      step(1);  check_output("b_grant2", 32'(ack_b), 32'h4);
      step(16); check_output("b_ack_gap3", 32'(ack_b), 32'h0);
      step(1);  check_output("b_grant3", 32'(ack_b), 32'h8);
      step(16); check_output("b_ack_gap4", 32'(ack_b), 32'h0);
      step(1);  check_output("b_grant4", 32'(ack_b), 32'h1);

      // Reset right after a grant clears ACK, DATA and ptr
      rst_b = 1'b0;
      #2;
      check_output("b_reset2_ack", 32'(ack_b), 32'h0);
      check_output("b_reset2_data", 32'(data_b), 32'h0);
      step(1);
      rst_b = 1'b1;
      step(16); check_output("b_post_reset_gap", 32'(ack_b), 32'h0);
      step(1);  check_output("b_post_reset_ptr0", 32'(ack_b), 32'h1);
      req_b = 4'b0000;

      // One client, one-bit words: grant every other cycle, bits follow the seed
      c_bits = 8'hA1;
      rst_c = 1'b1; req_c = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(1); check_output($sformatf("c_fill_%0d", k), 32'(ack_c), 32'h0);
         step(1); check_output($sformatf("c_ack_%0d", k), 32'(ack_c), 32'h1);
         check_output($sformatf("c_bit_%0d", k), 32'(data_c), 32'(c_bits[7-k]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/random_word_arbiter.md
# random_word_arbiter

Shares one `Lfsr` pseudo-random bit source among `Clients` requesters and hands each granted requester a `Width`-bit random word. The block enables the LFSR for exactly `Width` cycles to assemble a word, then parks until a request arrives. It grants round-robin with a one-cycle `ACK` pulse and a stable `DATA` word. It sits between the LFSR and consumers such as dither, scrambling and test-pattern logic that must never receive the same random bits.

## Interface
- `Clients`, 4: number of requesters; must be at least 1.
- `Width`, 16: bits per delivered word; must be at least 1.
- `Length`, 48: LFSR length, passed to `Lfsr`.
- `Taps`, 'h8000_0000_005C: LFSR tap mask, passed to `Lfsr`.
- `Seed`, 'hA1EA_1AC7_AE57: LFSR power-up value, passed to `Lfsr`.
- `CLK` input 1: the single clock; all state updates on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `REQ` input `Clients`: per-client request, level-sensitive.
- `ACK` output `Clients`: one-hot grant pulse, one cycle long.
- `DATA` output `Width`: word for the most recent grant.

## Operation
- The state machine has two states: FILL and READY. Reset state is FILL.
- **FILL**
  - `Lfsr.OE` is 1.
  - Each edge: `word <= {word[Width-2:0], Lfsr.OUT}` and `count <= count+1`.
  - Leave for READY on the edge where `count == Width-1`, and clear `count`.
- **READY**
  - `Lfsr.OE` is 0, so the LFSR holds its state.
  - If `REQ` is all zero, stay in READY. `ACK` stays 0.
  - If any `REQ` bit is 1:
    - The winner is the first set bit searching from `ptr` upward, wrapping modulo `Clients`.
    - At the edge: `ACK <= onehot(winner)`, `DATA <= word`, `ptr <= (winner+1) mod Clients`, state returns to FILL.
- `REQ` is sampled only in READY. Requests raised during FILL wait; they are not lost.
- `REQ` still high in the cycle after `ACK` counts as a new request. A requester wanting one word drops `REQ` when it sees `ACK`.
- The width of `count` is `$clog2(Width)`, minimum 1. With `Width == 1`, FILL lasts exactly one cycle.
- With `Clients == 1`, `ptr` stays 0 and the search is trivial.
- `DATA` changes only on a grant edge. Between grants it holds the last granted word.
- No word is ever given to two grants. Undelivered bits are never visible on `DATA`.

## Timing
- **Reset values:** `ACK` = 0, `DATA` = 0, `ptr` = 0, `count` = 0, `word` = 0, state FILL.
- **Reset has no effect on the LFSR.** `Lfsr` has no reset, so its sequence simply continues across a reset.
- **`OE` during reset:** `OE` is forced to 0 while `RST_N` is low, so the LFSR does not shift during reset.
- **Reset mid-FILL:** the partial word is discarded. The next word is built from the next `Width` LFSR bits.
- **Reset in READY:** the completed word is discarded. A fresh FILL starts.
- **First word after reset:** READY is reached after `Width` FILL cycles.
- **Grant latency:** `REQ` held in a READY cycle produces `ACK` in the very next cycle.
- **Throughput:** minimum `Width+1` cycles per word under continuous request.
- **`ACK` cycle:** `ACK` is high during the first FILL cycle of the next word. `DATA` is valid from the `ACK` cycle onward.
- **Simultaneous requests:** exactly one grant per word. Other requesters keep `REQ` high and are served in round-robin order.

## Structure
- **Shared package:** holds the state enum (FILL, READY) and a round-robin pick function (`REQ`, `ptr` → winner index plus a valid bit). Other arbiters in the design reuse both.
- **Sub-module:** one instance of `Lfsr`, with `Length`, `Taps` and `Seed` passed through.
- **Control logic:** everything else is a single always_ff with asynchronous reset, plus combinational `OE` and winner logic.

## Test plan
1. **Single client, defaults.** After reset, hold `REQ[0]`=1.
   - `ACK[0]` pulses at cycles 17, 34 and 51.
   - `DATA` = 'hA1EA, then 'h1AC7, then 'hAE57.
2. **All four `REQ` high continuously.** Grants go 0, 1, 2, 3, 0, … with exactly one `ACK` bit per grant and a `Width+1`-cycle spacing.
3. **Only `REQ[2]` pulses, raised during FILL.**
   - `ACK[2]` arrives one cycle after READY is entered.
   - With `REQ` low, the LFSR holds: the next delivered word is unchanged by idle time.
4. **`RST_N` pulsed low at FILL `count` = 7.**
   - `ACK`, `DATA` and `ptr` all return to 0.
   - The next word consists of LFSR bits 8..23 of the stream, i.e. 'hEA1A, not 'hA1EA. This checks `OE` gating during reset.
5. **`REQ[1]` and `REQ[3]` high with `ptr` = 2.** Client 3 wins first, `ptr` becomes 0, then client 1 wins.
6. **`Width` = 1, `Clients` = 1.**
   - The bits on `DATA` follow `Lfsr.OUT`: 1, 0, 1, 0, 0, 0, 0, 1, …
   - `ACK` pulses every 2 cycles.
